// File: rtl/minitb_ahb_pkg.sv
// minitb_ahb_pkg: shared AHB-lite transfer encodings, slave states and wait limit
package minitb_ahb_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11} htrans_t;
  typedef enum logic [1:0] {ADDR = 2'b00, WAIT = 2'b01, DATA = 2'b10} state_t;
  localparam int MAX_WAIT = 15;
endpackage

// File: rtl/minitb_ahb_slave_ram.sv
// minitb_ahb_slave_ram: word array with sync write, registered read and write-to-read forwarding
module minitb_ahb_slave_ram #(
  parameter int addrWidth = 8,
  parameter int dataWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [addrWidth-1:0] wr_addr,
  input  logic [dataWidth-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [addrWidth-1:0] rd_addr,
  output logic [dataWidth-1:0] rd_data
);
  logic [dataWidth-1:0] mem [2**addrWidth];
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;
  // a read landing on the edge that commits the same word must see the new data
  always_ff @(posedge clk or posedge rst)
    if (rst) rd_data <= '0;
    else if (rd_en) rd_data <= (wr_en && wr_addr == rd_addr) ? wr_data : mem[rd_addr];
endmodule

// File: rtl/minitb_ahb_slave.sv
// minitb_ahb_slave: AHB-lite memory slave for the miniTB master BFM
// MINITB_AHB_SLAVE_WAIT_EN adds waitStates data-phase wait cycles per transfer
module minitb_ahb_slave
  import minitb_ahb_pkg::*;
#(
  parameter int addrWidth  = 8,
  parameter int dataWidth  = 32,
  parameter int waitStates = 0
) (
  input  logic                 hclk,
  input  logic                 hreset,
  input  logic                 hsel,
  input  logic [1:0]           htrans,
  input  logic [addrWidth-1:0] haddr,
  input  logic                 hwrite,
  input  logic [dataWidth-1:0] hwdata,
  output logic [dataWidth-1:0] hrdata,
  output logic                 hready
);
`ifdef MINITB_AHB_SLAVE_WAIT_EN
  localparam bit wait_en = 1'b1;
`else
  localparam bit wait_en = 1'b0;
`endif
  localparam int wait_n   = waitStates > MAX_WAIT ? MAX_WAIT : waitStates;
  localparam bit use_wait = wait_en && wait_n > 0;
  state_t state, state_nx;
  logic dp_valid, dp_write, accept, wait_done, rd_en, wr_en;
  logic [addrWidth-1:0] dp_addr, rd_addr;
  assign accept = hready && hsel && (htrans == NONSEQ || htrans == SEQ);
  always_comb
    state_nx = accept ? (use_wait ? WAIT : DATA) : state == WAIT ? (wait_done ? DATA : WAIT) : ADDR;
  // zero-wait reads load from the live address; stretched reads load from the captured one
  assign rd_en   = (accept && !hwrite && !use_wait) || (state == WAIT && wait_done && !dp_write);
  assign rd_addr = state == WAIT ? dp_addr : haddr;
  assign wr_en   = state == DATA && dp_valid && dp_write;
  always_ff @(posedge hclk or posedge hreset)
    if (hreset) begin
      state    <= ADDR;
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= '0;
    end else begin
      state    <= state_nx;
      dp_valid <= state_nx != ADDR;
      if (accept) begin
        dp_write <= hwrite;
        dp_addr  <= haddr;
      end
    end
`ifdef MINITB_AHB_SLAVE_WAIT_EN
  logic [3:0] wait_cnt;
  always_ff @(posedge hclk or posedge hreset)
    if (hreset) wait_cnt <= 4'd0;
    else if (accept) wait_cnt <= 4'(wait_n);
    else if (state == WAIT) wait_cnt <= wait_cnt - 4'd1;
  assign wait_done = wait_cnt == 4'd1;
  assign hready    = state != WAIT;
`else
  assign wait_done = 1'b1;
  assign hready    = 1'b1;
`endif
  minitb_ahb_slave_ram #(.addrWidth(addrWidth), .dataWidth(dataWidth)) u_ram (
    .clk    (hclk),
    .rst    (hreset),
    .wr_en  (wr_en),
    .wr_addr(dp_addr),
    .wr_data(hwdata),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .rd_data(hrdata)
  );
endmodule

// File: tb/tb_minitb_ahb_slave.sv
// tb_minitb_ahb_slave: table-driven pipelined bus driver with a read-data scoreboard
module tb_minitb_ahb_slave;
  import minitb_ahb_pkg::*;
`ifdef MINITB_AHB_SLAVE_WAIT_EN
  localparam int W = 3;
`else
  localparam int W = 0;
`endif
  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        write;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  logic hclk, hreset, hsel, hwrite, hready;
  logic [1:0] htrans;
  logic [7:0] haddr;
  logic [31:0] hwdata, hrdata;
  int passed = 0, total = 0;
  logic [31:0] q[$];
  logic [31:0] last_rd = 32'h0, pend_wdata = 32'h0;
  logic pend_valid = 1'b0, pend_write = 1'b0;
  vec_t tbl[16];
  minitb_ahb_slave #(.addrWidth(8), .dataWidth(32), .waitStates(3)) dut (
    .hclk(hclk), .hreset(hreset), .hsel(hsel), .htrans(htrans), .haddr(haddr),
    .hwrite(hwrite), .hwdata(hwdata), .hrdata(hrdata), .hready(hready)
  );
  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic run_vec(input vec_t v, input bit wiggle);
    int stall = 0;
    hsel = v.sel; htrans = v.trans; haddr = v.addr; hwrite = v.write; hwdata = pend_wdata;
    @(negedge hclk);
    while (!hready && stall < 40) begin
      stall++;
      if (wiggle) haddr = 8'(stall * 37);
      @(negedge hclk);
    end
    haddr = v.addr;
    if (pend_valid) chk("stall_cycles", 32'(stall), 32'(W));
    if (pend_valid && !pend_write) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL scoreboard: read completed with empty queue, got %h", hrdata);
      end else begin
        last_rd = q.pop_front();
        chk("read_data", hrdata, last_rd);
      end
    end else chk("hrdata_hold", hrdata, last_rd);
    @(posedge hclk);
    #1;
    pend_valid = v.sel && v.trans[1];
    pend_write = v.write;
    pend_wdata = v.write ? v.wdata : 32'h0BAD0BAD;
    if (pend_valid && !v.write) q.push_back(v.exp);
  endtask
  vec_t idle_v, rd10_v, wr40_v, rd40_v;
  initial begin
    tbl[0]  = '{1'b1, NONSEQ, 1'b1, 8'h10, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{1'b1, IDLE,   1'b0, 8'h10, 32'h0,        32'h0};
    tbl[2]  = '{1'b1, NONSEQ, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF};
    tbl[3]  = '{1'b1, NONSEQ, 1'b1, 8'h20, 32'h12345678, 32'h0};
    tbl[4]  = '{1'b1, NONSEQ, 1'b0, 8'h20, 32'h0,        32'h12345678};
    tbl[5]  = '{1'b1, NONSEQ, 1'b1, 8'h30, 32'hAAAA5555, 32'h0};
    tbl[6]  = '{1'b1, BUSY,   1'b1, 8'h30, 32'hFFFFFFFF, 32'h0};
    tbl[7]  = '{1'b0, NONSEQ, 1'b1, 8'h30, 32'hFFFFFFFF, 32'h0};
    tbl[8]  = '{1'b1, NONSEQ, 1'b0, 8'h30, 32'h0,        32'hAAAA5555};
    tbl[9]  = '{1'b1, SEQ,    1'b1, 8'h31, 32'h0BADF00D, 32'h0};
    tbl[10] = '{1'b1, NONSEQ, 1'b1, 8'h21, 32'h11111111, 32'h0};
    tbl[11] = '{1'b1, NONSEQ, 1'b0, 8'h20, 32'h0,        32'h12345678};
    tbl[12] = '{1'b1, SEQ,    1'b0, 8'h31, 32'h0,        32'h0BADF00D};
    tbl[13] = '{1'b1, NONSEQ, 1'b1, 8'h40, 32'h01020304, 32'h0};
    tbl[14] = '{1'b1, IDLE,   1'b1, 8'h40, 32'hFFFFFFFF, 32'h0};
    tbl[15] = '{1'b1, NONSEQ, 1'b0, 8'h40, 32'h0,        32'h01020304};
    idle_v = '{1'b0, IDLE,   1'b0, 8'h00, 32'h0,        32'h0};
    rd10_v = '{1'b1, NONSEQ, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF};
    wr40_v = '{1'b1, NONSEQ, 1'b1, 8'h40, 32'hA5A5A5A5, 32'h0};
    rd40_v = '{1'b1, NONSEQ, 1'b0, 8'h40, 32'h0,        32'h01020304};
    hreset = 1'b1; hsel = 1'b0; htrans = IDLE; haddr = 8'h0; hwrite = 1'b0; hwdata = 32'h0;
    @(negedge hclk);
    chk("reset_hready", 32'(hready), 32'h1);
    chk("reset_hrdata", hrdata, 32'h0);
    @(posedge hclk);
    #1 hreset = 1'b0;
    for (int i = 0; i < 2; i++) run_vec(idle_v, 1'b0);
    for (int i = 0; i < 16; i++) run_vec(tbl[i], 1'b0);
    run_vec(rd10_v, 1'b1);
    run_vec(idle_v, 1'b0);
    run_vec(wr40_v, 1'b0);
    hsel = 1'b0; htrans = IDLE; hwdata = 32'hA5A5A5A5;
    @(negedge hclk);
    hreset = 1'b1;
    #1;
    chk("async_rst_hready", 32'(hready), 32'h1);
    chk("async_rst_hrdata", hrdata, 32'h0);
    @(posedge hclk);
    #1 hreset = 1'b0;
    pend_valid = 1'b0; last_rd = 32'h0;
    run_vec(rd40_v, 1'b0);
    run_vec(idle_v, 1'b0);
    run_vec(idle_v, 1'b0);
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/minitb_ahb_slave.md
# minitb_ahb_slave

Synthesizable AHB-lite memory slave that consumes the transfers produced by the miniTB AHB master BFM. It decodes single NONSEQ read/write transfers, stores write data in an internal word array, and returns read data in the data phase. An optional wait-state generator stretches data phases so benches can exercise `hready` handling.

## Interface
Parameters:
- `addrWidth`, 8: `haddr` width; array depth is 2**addrWidth words, word-addressed.
- `dataWidth`, 32: `hwdata` and `hrdata` width.
- `waitStates`, 0: data-phase wait cycles per transfer, range 0..15. Used only when the wait macro is defined.

Ports:
- `hclk`  input  1  bus clock; all state changes on its rising edge.
- `hreset`  input  1  asynchronous, active-high reset.
- `hsel`  input  1  slave select from the decoder.
- `htrans`  input  2  transfer type.
- `haddr`  input  addrWidth  word address.
- `hwrite`  input  1  1 = write, 0 = read.
- `hwdata`  input  dataWidth  write data, valid in the data phase.
- `hrdata`  output  dataWidth  read data, registered.
- `hready`  output  1  data-phase completion and bus ready. Also sampled internally as the bus `hready`, because this is a single-slave system.

## Operation
- Accept condition: an address phase is accepted at a rising edge when `hready && hsel && htrans[1]`.
  - NONSEQ (2'b10) and SEQ (2'b11) are both accepted as single transfers.
  - IDLE (2'b00) and BUSY (2'b01) are ignored.
- On accept, the following are registered: `dpValid`=1, `dpWrite`=`hwrite`, `dpAddr`=`haddr`.
- State machine:
  - ADDR: no data phase pending.
  - DATA: final data-phase cycle, `hready`=1.
  - WAIT: stretched data-phase cycle, `hready`=0; exists only with the macro.
- Transitions:
  - ADDR -> DATA on accept when `waitStates`=0.
  - ADDR -> WAIT on accept when `waitStates`>0.
  - WAIT -> DATA when the wait counter reaches 1.
  - DATA -> DATA on a new accept.
  - DATA -> ADDR when there is no new accept.
- Write commit: at the rising edge ending a write DATA cycle, `mem[dpAddr]` <= `hwdata`.
- Read load: `hrdata` <= `mem[addr]` at the edge entering DATA for a read.
  - `addr` is `haddr` when entering from ADDR or DATA.
  - `addr` is `dpAddr` when entering from WAIT.
- Read forwarding: if the read load coincides with a write commit to the same address, `hrdata` <= `hwdata`.
- `hrdata` holds its value between reads. It does not change on writes or on idle cycles.
- Pipelining: back-to-back transfers are supported. The next address phase overlaps the current DATA cycle.
- No error response. All addresses map to the array.

## Timing
- Reset values: `hrdata`=0, `hready`=1, `dpValid`=0, state ADDR, wait counter 0. Array contents are not reset.
- Zero-wait latency:
  - Address accepted at edge N.
  - Read data is valid from edge N until edge N+1.
  - Write data is sampled and committed at edge N+1.
- With `waitStates`=W:
  - `hready`=0 for W cycles after edge N.
  - `hready`=1 in cycle N+W, and the transfer completes at edge N+W+1.
- A new address phase is never accepted while `hready`=0. Address and control must be held by the master.
- Reset asserted mid-transfer:
  - The pending write is discarded and not committed.
  - `hready` returns to 1 and `hrdata` returns to 0 immediately (asynchronous).
- Reset release: the first accept is possible at the first rising edge with `hreset`=0.

## Configuration
- Macro: `MINITB_AHB_SLAVE_WAIT_EN`.
- Defined:
  - A 4-bit wait counter is loaded with `waitStates` on each accept.
  - The WAIT state is present and `hready` is driven low during WAIT.
- Undefined:
  - No counter and no WAIT state.
  - `hready` is constant 1 and `waitStates` is ignored.
  - Cycle behaviour matches `waitStates`=0.

## Structure
- Package `minitb_ahb_pkg` holds:
  - `htrans` encodings: IDLE, BUSY, NONSEQ, SEQ.
  - The slave state enum: ADDR, WAIT, DATA.
  - The constant `MAX_WAIT`=15.
- Sub-module `minitb_ahb_slave_ram`: the storage array, with one synchronous write port and one synchronous read port plus the forwarding mux.
- The top level contains the address-phase registers, the FSM and the wait counter.

## Test plan
- Reset, then idle cycles -> `hready`=1, `hrdata`=0, array untouched.
- Write 0x10 <= 0xDEADBEEF, then read 0x10 with zero wait -> `hrdata`=0xDEADBEEF in the read data phase.
- Back-to-back write 0x20 <= 0x12345678 immediately followed by read 0x20 -> forwarded 0x12345678 with no stall.
- Macro defined, `waitStates`=3, read 0x10 -> `hready` low for exactly 3 cycles, then data 0xDEADBEEF; `haddr` changes during the stall are ignored.
- `htrans`=BUSY, or `hsel`=0 with NONSEQ write 0x30 <= 0xFFFFFFFF -> no commit; a later read of 0x30 returns the old value.
- Assert `hreset` during the write data phase of 0x40 <= 0xA5A5A5A5 -> `hready`=1, `hrdata`=0 asynchronously; a read of 0x40 after release returns the prior contents.
